// File: rtl/mem_reader_pkg.sv
// Shared definitions for the state-memory fill/read engines: default geometry
// and the reader FSM state encoding.
package mem_reader_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam logic [AW_DEF-1:0] LAST_ADDR = {AW_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/mem_reader_skid_fifo2.sv
// Two-entry FIFO with occupancy count; the head entry is always a register,
// so consumers never see a combinational path from the write side.
module skid_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         full;

    assign empty  = (count_q == 2'd0);
    assign full   = (count_q == 2'd2);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign do_pop = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The upstream credit rule must never let a write land on a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mem_reader.sv
// Sweeps the state memory from address 0 to LAST, streams each byte out over
// valid/ready and flags the first byte that differs from its own address.
module mem_reader
    import mem_reader_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          rdy,
    output logic          done,
    output logic [AW-1:0] addr,
    output logic          rden,
    input  logic [DW-1:0] rddata,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          mismatch,
    output logic [AW-1:0] bad_addr
);

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    rd_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [AW-1:0] bad_addr_q, bad_addr_d;
    logic          rdy_q, rdy_d;
    logic          done_q, done_d;
    logic          mismatch_q, mismatch_d;
    logic          inflight_q, inflight_d;

    logic [1:0]       fifo_count;
    logic             fifo_empty;
    logic [AW+DW-1:0] fifo_head;
    logic             pop;
    logic             issue;
    logic [2:0]       occupancy;

    // Credit counts what the buffer will hold once this cycle's pop and the
    // in-flight capture settle, so a full-rate stream never overflows it.
    assign pop       = !fifo_empty && out_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ST_READ) && (occupancy < 3'd2);

    skid_fifo2 #(
        .W (AW + DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({tag_q, rddata}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rdy       = rdy_q;
    assign done      = done_q;
    assign addr      = addr_q;
    assign rden      = issue;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[DW-1:0];
    assign mismatch  = mismatch_q;
    assign bad_addr  = bad_addr_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rdy_d      = rdy_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        bad_addr_d = bad_addr_q;
        inflight_d = issue;
        tag_d      = issue ? addr_q : tag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_READ;
                    rdy_d      = 1'b0;
                    mismatch_d = 1'b0;
                    bad_addr_d = '0;
                    addr_d     = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (addr_q == LAST) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    done_d  = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Only the first bad byte of a sweep is recorded.
        if (inflight_q && !mismatch_q && (rddata != DW'(tag_q))) begin
            mismatch_d = 1'b1;
            bad_addr_d = tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tag_q      <= '0;
            bad_addr_q <= '0;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            bad_addr_q <= bad_addr_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            inflight_q <= inflight_d;
        end
    end

    a_rd_lat_supported: assert property (@(posedge clk) RD_LAT == 1);

    // While no mismatch has been seen, every buffered byte still equals its tag.
    a_head_matches_tag: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !mismatch_q) |-> (fifo_head[DW-1:0] == DW'(fifo_head[AW+DW-1:DW])));

endmodule

// File: tb/tb_mem_reader.sv
// Scoreboard bench for mem_reader: expected bytes are queued when a sweep is
// started and a free-running monitor checks every accepted output byte.
module tb_mem_reader;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       en        = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] rddata    = 8'h00;
    logic       rdy, done, rden, out_valid, mismatch;
    logic [7:0] addr, out_data, bad_addr;

    logic [7:0] ram [256];
    logic [7:0] exp_q [$];
    int n_checks   = 0;
    int n_fail     = 0;
    int issued     = 0;
    int popped     = 0;
    int ready_mode = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    mem_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .done      (done),
        .addr      (addr),
        .rden      (rden),
        .rddata    (rddata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mismatch  (mismatch),
        .bad_addr  (bad_addr)
    );

    // Synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (rden) rddata <= ram[addr];
    end

    // Consumer: 0 = always ready, 1 = toggling, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: actual no event within budget, required event", name);
    endtask

    // Monitor: scoreboard pops, buffer-occupancy bound and stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            checkOutput("occupancy_le_2", 32'((issued - popped) <= 2), 32'd1);
            if (prev_stall) begin
                checkOutput("stall_valid_held", 32'(out_valid), 32'd1);
                checkOutput("stall_data_held", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_byte: actual 0x%0h, required no byte", out_data);
                end else begin
                    checkOutput("stream_byte", 32'(out_data), 32'(exp_q.pop_front()));
                end
                popped++;
            end
            if (rden) issued++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rdy"},       32'(rdy),       32'd1);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_addr"},      32'(addr),      32'd0);
        checkOutput({tag, "_rden"},      32'(rden),      32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_data"},  32'(out_data),  32'd0);
        checkOutput({tag, "_mismatch"},  32'(mismatch),  32'd0);
        checkOutput({tag, "_bad_addr"},  32'(bad_addr),  32'd0);
    endtask

    task automatic pushExpected();
        for (int i = 0; i < 256; i++) exp_q.push_back(ram[i]);
    endtask

    // Starts a sweep: en is raised in what the checks call cycle 0
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        issued = 0;
        popped = 0;
        exp_q.delete();
        pushExpected();
        en = 1'b1;
    endtask

    // Returns the cycle (relative to the caller's cycle 0) in which done was seen
    task automatic waitDone(input int budget, input bit hold_en, output int cyc_done, output int cyc_first);
        cyc_done  = -1;
        cyc_first = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (!hold_en)      en = 1'b0;
            else if (c == 100) en = 1'b0;
            else if (c == 101) en = 1'b1;
            @(negedge clk);
            if (out_valid && cyc_first < 0) cyc_first = c;
            if (done) begin
                cyc_done = c;
                break;
            end
        end
        if (cyc_done < 0) reportTimeout("done_timeout");
    endtask

    initial begin
        int  dc, fv;
        bit  found;

        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        ready_mode = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] test 1: identity sweep, consumer always ready");
        applyStimulus();
        waitDone(400, 1'b0, dc, fv);
        checkOutput("t1_first_valid", 32'(fv), 32'd3);
        checkOutput("t1_done_cycle", 32'(dc), 32'd260);
        checkOutput("t1_rdy_at_done", 32'(rdy), 32'd1);
        checkOutput("t1_mismatch", 32'(mismatch), 32'd0);
        checkOutput("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t1_bytes", 32'(popped), 32'd256);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(done), 32'd0);
        checkOutput("t1_rdy_after", 32'(rdy), 32'd1);

        $display("[TB] test 2: toggling backpressure");
        ready_mode = 1;
        applyStimulus();
        waitDone(900, 1'b0, dc, fv);
        checkOutput("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t2_bytes", 32'(popped), 32'd256);
        checkOutput("t2_mismatch", 32'(mismatch), 32'd0);
        ready_mode = 0;

        $display("[TB] test 3: corrupted bytes at 0x37 and 0x90");
        ram[8'h37] = 8'h00;
        ram[8'h90] = 8'h01;
        applyStimulus();
        found = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1 en = 1'b0;
            @(negedge clk);
            if (rden && addr == 8'h37) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            reportTimeout("t3_read_0x37");
        end else begin
            @(negedge clk);
            checkOutput("t3_mismatch_before_capture", 32'(mismatch), 32'd0);
            @(negedge clk);
            checkOutput("t3_mismatch_after_capture", 32'(mismatch), 32'd1);
            checkOutput("t3_bad_addr_after_capture", 32'(bad_addr), 32'h37);
        end
        waitDone(400, 1'b0, dc, fv);
        checkOutput("t3_mismatch_at_done", 32'(mismatch), 32'd1);
        checkOutput("t3_bad_addr_at_done", 32'(bad_addr), 32'h37);
        checkOutput("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        ram[8'h37] = 8'h37;
        ram[8'h90] = 8'h90;

        $display("[TB] test 4: consumer stalled for 50 cycles");
        ready_mode = 2;
        applyStimulus();
        repeat (50) begin
            @(posedge clk);
            #1 en = 1'b0;
        end
        @(negedge clk);
        checkOutput("t4_reads_issued", 32'(issued), 32'd2);
        checkOutput("t4_addr_stalled", 32'(addr), 32'd2);
        checkOutput("t4_rden_off", 32'(rden), 32'd0);
        ready_mode = 0;
        waitDone(400, 1'b0, dc, fv);
        checkOutput("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t4_bytes", 32'(popped), 32'd256);
        checkOutput("t4_mismatch", 32'(mismatch), 32'd0);

        $display("[TB] test 5: reset in the middle of a sweep");
        applyStimulus();
        @(posedge clk);
        #1 en = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (popped >= 100) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) reportTimeout("t5_byte_100");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        issued = 0;
        popped = 0;
        @(negedge clk);
        checkResetValues("t5_mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus();
        waitDone(400, 1'b0, dc, fv);
        checkOutput("t5_done_cycle", 32'(dc), 32'd260);
        checkOutput("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t5_bytes", 32'(popped), 32'd256);

        $display("[TB] test 6: en held high with a mid-sweep re-pulse");
        applyStimulus();
        waitDone(400, 1'b1, dc, fv);
        checkOutput("t6_done_cycle", 32'(dc), 32'd260);
        checkOutput("t6_rdy_at_done", 32'(rdy), 32'd1);
        checkOutput("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        pushExpected();
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        checkOutput("t6_restart_rdy", 32'(rdy), 32'd0);
        checkOutput("t6_restart_rden", 32'(rden), 32'd1);
        checkOutput("t6_restart_addr", 32'(addr), 32'd0);
        // Counted from the cycle after the restart edge, so one less than a full sweep
        waitDone(400, 1'b0, dc, fv);
        checkOutput("t6_second_done_cycle", 32'(dc), 32'd259);
        checkOutput("t6_second_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("t6_second_mismatch", 32'(mismatch), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
